// File: rtl/timer_bank_pkg.sv
// Shared types and defaults for the timer bank: prescale encodings, channel
// mode and the default interrupt vector layout.
package timer_bank_pkg;

  typedef enum logic [1:0] {
    PRESC_1  = 2'd0,
    PRESC_4  = 2'd1,
    PRESC_16 = 2'd2,
    PRESC_64 = 2'd3
  } presc_e;

  typedef enum logic {
    ONESHOT  = 1'b0,
    PERIODIC = 1'b1
  } mode_e;

  localparam int unsigned   PRESC_W        = 6;
  localparam logic [9:0]    VEC_BASE_DEF   = 10'h384;
  localparam int unsigned   VEC_STRIDE_DEF = 4;

  // Strobe vector indexed by presc_e, derived from the shared prescaler count.
  function automatic logic [3:0] presc_strobes(input logic [PRESC_W-1:0] cnt);
    presc_strobes = {&cnt[5:0], &cnt[3:0], &cnt[1:0], 1'b1};
  endfunction

endpackage

// File: rtl/timer_bank_chan.sv
// One timer channel: holds its configuration and down-counter, and flags an
// expiry on the selected prescale strobe when the count has reached zero.
module timer_chan
  import timer_bank_pkg::*;
#(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    strobe,
  input  logic          we,
  input  logic [CW-1:0] cfg_period,
  input  logic [1:0]    cfg_presc,
  input  logic          cfg_periodic,
  input  logic          cfg_en,
  input  logic          cfg_ie,
  output logic          expire,
  output logic          tick,
  output logic          ie
);

  logic [CW-1:0] count;
  logic [CW-1:0] period;
  presc_e        presc;
  mode_e         mode;
  logic          en;
  logic          step;

  // A write in the same cycle suppresses the expiry entirely.
  always_comb begin
    step   = en && strobe[presc];
    expire = step && (count == '0) && !we;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      period <= '0;
      presc  <= PRESC_1;
      mode   <= ONESHOT;
      en     <= 1'b0;
      ie     <= 1'b0;
      tick   <= 1'b0;
    end else begin
      tick <= expire;
      if (we) begin
        count  <= cfg_period;
        period <= cfg_period;
        presc  <= presc_e'(cfg_presc);
        mode   <= cfg_periodic ? PERIODIC : ONESHOT;
        en     <= cfg_en;
        ie     <= cfg_ie;
      end else if (step) begin
        if (count == '0) begin
          if (mode == PERIODIC) count <= period;
          else                  en    <= 1'b0;
        end else begin
          count <= count - CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/timer_bank.sv
// Bank of NCH programmable timers sharing one prescaler, with a fixed-priority
// interrupt presenter (lowest channel first) and per-channel jump vectors.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int unsigned    NCH        = 4,
  parameter int unsigned    CW         = 8,
  parameter int unsigned    VW         = 10,
  parameter logic [VW-1:0]  VEC_BASE   = VW'(VEC_BASE_DEF),
  parameter int unsigned    VEC_STRIDE = VEC_STRIDE_DEF,
  localparam int unsigned   CHW        = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_period,
  input  logic [1:0]     cfg_presc,
  input  logic           cfg_periodic,
  input  logic           cfg_en,
  input  logic           cfg_ie,
  input  logic           irq_ack,
  output logic [NCH-1:0] tick,
  output logic           irq,
  output logic [CHW-1:0] irq_ch,
  output logic [VW-1:0]  irq_vec
);

  logic [1:0]         rst_sync;
  logic               rst_n;
  logic [PRESC_W-1:0] presc_cnt;
  logic [3:0]         strobe;
  logic [NCH-1:0]     ch_we;
  logic [NCH-1:0]     expire;
  logic [NCH-1:0]     ie;
  logic [NCH-1:0]     pending;
  logic [NCH-1:0]     ack_clr;

  // Assert immediately, release two clocks later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc_cnt <= '0;
    else        presc_cnt <= presc_cnt + PRESC_W'(1);
  end
  assign strobe = presc_strobes(presc_cnt);

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    assign ch_we[g] = cfg_we && (cfg_ch == CHW'(g));

    timer_chan #(
      .CW(CW)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .strobe       (strobe),
      .we           (ch_we[g]),
      .cfg_period   (cfg_period),
      .cfg_presc    (cfg_presc),
      .cfg_periodic (cfg_periodic),
      .cfg_en       (cfg_en),
      .cfg_ie       (cfg_ie),
      .expire       (expire[g]),
      .tick         (tick[g]),
      .ie           (ie[g])
    );
  end

  always_comb begin
    ack_clr = '0;
    if (irq_ack && irq) ack_clr[irq_ch] = 1'b1;
  end

  // A fresh expiry overrides an acknowledge of the same channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= (pending & ~(ch_we | ack_clr)) | expire;
  end

  always_comb begin
    logic [NCH-1:0] req;
    logic           found;
    req    = pending & ie;
    irq    = |req;
    irq_ch = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (req[i] && !found) begin
        found  = 1'b1;
        irq_ch = CHW'(i);
      end
    end
    irq_vec = VEC_BASE + VW'(VEC_STRIDE * 32'(irq_ch));
  end

endmodule

// File: tb/tb_timer_bank.sv
// Randomised and directed checks of timer_bank against a behavioural model.
module tb_timer_bank;

  localparam int NCH        = 4;
  localparam int CW         = 8;
  localparam int VW         = 10;
  localparam int VEC_BASE   = 'h384;
  localparam int VEC_STRIDE = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_ch = '0;
  logic [CW-1:0] cfg_period = '0;
  logic [1:0]    cfg_presc = '0;
  logic          cfg_periodic = 1'b0;
  logic          cfg_en = 1'b0;
  logic          cfg_ie = 1'b0;
  logic          irq_ack = 1'b0;
  logic [NCH-1:0] tick;
  logic           irq;
  logic [1:0]     irq_ch;
  logic [VW-1:0]  irq_vec;

  int n_checks = 0;
  int n_err = 0;

  // Model state
  int m_pre;
  int m_rel;
  int m_count[NCH];
  int m_period[NCH];
  int m_div[NCH];
  bit m_periodic[NCH];
  bit m_en[NCH];
  bit m_ie[NCH];
  bit m_pend[NCH];
  bit m_tick[NCH];

  timer_bank #(
    .NCH(NCH), .CW(CW), .VW(VW), .VEC_BASE(10'h384), .VEC_STRIDE(VEC_STRIDE)
  ) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_presc(cfg_presc), .cfg_periodic(cfg_periodic),
    .cfg_en(cfg_en), .cfg_ie(cfg_ie), .irq_ack(irq_ack),
    .tick(tick), .irq(irq), .irq_ch(irq_ch), .irq_vec(irq_vec)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_irq(output int ch);
    ch = 0;
    for (int i = 0; i < NCH; i++)
      if (m_pend[i] && m_ie[i]) begin
        ch = i;
        return 1'b1;
      end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_pre = 0;
    m_rel = 0;
    for (int i = 0; i < NCH; i++) begin
      m_count[i] = 0; m_period[i] = 0; m_div[i] = 1; m_periodic[i] = 0;
      m_en[i] = 0; m_ie[i] = 0; m_pend[i] = 0; m_tick[i] = 0;
    end
  endtask

  // One clock edge of the specified behaviour, using the inputs before the edge.
  task automatic model_step();
    bit any, wr, hit, ex;
    int ack_ch;
    if (!reset) begin
      model_reset();
      return;
    end
    if (m_rel < 2) begin
      m_rel++;
      return;
    end
    any = model_irq(ack_ch);
    for (int i = 0; i < NCH; i++) begin
      wr  = cfg_we && (int'(cfg_ch) == i);
      hit = m_en[i] && ((m_pre % m_div[i]) == m_div[i] - 1);
      ex  = hit && (m_count[i] == 0) && !wr;
      if (wr) begin
        m_count[i]    = int'(cfg_period);
        m_period[i]   = int'(cfg_period);
        m_div[i]      = 1 << (2 * int'(cfg_presc));
        m_periodic[i] = cfg_periodic;
        m_en[i]       = cfg_en;
        m_ie[i]       = cfg_ie;
        m_pend[i]     = 0;
      end else if (hit) begin
        if (m_count[i] != 0)    m_count[i] = m_count[i] - 1;
        else if (m_periodic[i]) m_count[i] = m_period[i];
        else                    m_en[i] = 0;
      end
      if (ex) m_pend[i] = 1;
      else if (any && irq_ack && ack_ch == i) m_pend[i] = 0;
      m_tick[i] = ex;
    end
    m_pre = (m_pre + 1) % 64;
  endtask

  task automatic compare();
    int ech;
    bit eirq;
    logic [NCH-1:0] et;
    eirq = model_irq(ech);
    for (int i = 0; i < NCH; i++) et[i] = m_tick[i];
    check("tick", tick, et);
    check("irq", irq, eirq);
    check("irq_ch", irq_ch, ech);
    check("irq_vec", irq_vec, (VEC_BASE + ech * VEC_STRIDE) % (1 << VW));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    model_reset();
    #1;
    check("rst_tick", tick, 0);
    check("rst_irq", irq, 0);
    check("rst_irq_ch", irq_ch, 0);
    check("rst_irq_vec", irq_vec, 'h384);
    cfg_we = 0; irq_ack = 0;
    repeat (3) step();
    reset = 1'b1;
    repeat (2) step();
  endtask

  task automatic cfg(input int ch, input int period, input int presc,
                     input bit periodic, input bit en, input bit ie);
    cfg_ch = 2'(ch); cfg_period = CW'(period); cfg_presc = 2'(presc);
    cfg_periodic = periodic; cfg_en = en; cfg_ie = ie; cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
  endtask

  initial begin
    int cnt, first;
    model_reset();

    // ch0 P=3 /1 periodic: ticks every 4 clocks after the write
    do_reset();
    cfg(0, 3, 0, 1, 1, 1);
    for (int k = 1; k <= 8; k++) begin
      step();
      check("p3_tick0", tick[0], (k % 4) == 0);
      if (k == 4) begin
        check("p3_irq", irq, 1);
        check("p3_vec", irq_vec, 'h384);
      end
    end

    // ch1 P=0 /4 one-shot: single tick at the first strobe (prescaler phase 3)
    do_reset();
    cfg(1, 0, 1, 0, 1, 0);
    cnt = 0; first = 0;
    for (int k = 1; k <= 64; k++) begin
      step();
      if (tick[1]) begin
        cnt++;
        if (first == 0) first = k;
      end
    end
    check("oneshot_count", cnt, 1);
    check("oneshot_delay", first, 3);

    // priority and acknowledge order
    do_reset();
    cfg(1, 0, 0, 0, 1, 1);
    cfg(2, 0, 0, 0, 1, 1);
    step();
    check("prio_ch1", irq_ch, 1);
    check("prio_vec1", irq_vec, 'h388);
    irq_ack = 1; step(); irq_ack = 0;
    check("prio_irq2", irq, 1);
    check("prio_ch2", irq_ch, 2);
    check("prio_vec2", irq_vec, 'h38C);
    irq_ack = 1; step(); irq_ack = 0;
    check("prio_none", irq, 0);

    // ie=0 expiry is silent; ack colliding with new expiry keeps pending
    do_reset();
    cfg(3, 0, 0, 0, 1, 0);
    step();
    check("noie_tick3", tick[3], 1);
    check("noie_irq", irq, 0);
    cfg(2, 1, 0, 1, 1, 1);
    step(); step();
    check("coll_tick_a", tick[2], 1);
    check("coll_irq_a", irq, 1);
    step();
    irq_ack = 1; step(); irq_ack = 0;
    check("coll_tick_b", tick[2], 1);
    check("coll_irq_b", irq, 1);
    check("coll_ch", irq_ch, 2);
    irq_ack = 1; step(); irq_ack = 0;
    check("coll_cleared", irq, 0);

    // rewrite in the expiry cycle suppresses the tick and clears pending
    do_reset();
    cfg(0, 3, 0, 1, 1, 1);
    repeat (3) step();
    step();
    check("rw_tick_first", tick[0], 1);
    repeat (3) step();
    cfg(0, 2, 0, 1, 1, 1);
    check("rw_no_tick", tick[0], 0);
    check("rw_irq", irq, 0);
    step(); check("rw_gap1", tick[0], 0);
    step(); check("rw_gap2", tick[0], 0);
    step(); check("rw_tick_new", tick[0], 1);

    // reset mid-count, then ch0 stays idle
    cfg(0, 9, 0, 1, 1, 1);
    repeat (4) step();
    do_reset();
    cnt = 0;
    repeat (20) begin
      step();
      if (tick != 0) cnt++;
    end
    check("post_reset_idle", cnt, 0);

    // randomised traffic
    for (int k = 0; k < 3000; k++) begin
      if (k == 1500) do_reset();
      if ($urandom_range(0, 5) == 0) begin
        cfg_ch = 2'($urandom_range(0, 3));
        cfg_period = CW'($urandom_range(0, 12));
        cfg_presc = 2'($urandom_range(0, 3));
        cfg_periodic = 1'($urandom_range(0, 1));
        cfg_en = ($urandom_range(0, 4) != 0);
        cfg_ie = 1'($urandom_range(0, 1));
        cfg_we = 1'b1;
      end else begin
        cfg_we = 1'b0;
      end
      irq_ack = ($urandom_range(0, 3) == 0);
      step();
    end
    cfg_we = 0; irq_ack = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/timer_bank.md
TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 Parameters SHALL be (name, default, meaning): NCH, 4, channel count (2..8); CW, 8, counter/period width; VW, 10, vector width; VEC_BASE, 10'h384, vector of channel 0; VEC_STRIDE, 4, vector spacing per channel.
REQ-002 Ports SHALL be (name direction width meaning): clk in 1 sole clock, rising edge; reset in 1 asynchronous active-low reset.
REQ-003 cfg_we in 1 write strobe; cfg_ch in $clog2(NCH) target channel; cfg_period in CW reload value; cfg_presc in 2 prescale select (0:/1, 1:/4, 2:/16, 3:/64).
REQ-004 cfg_periodic in 1 (1 periodic, 0 one-shot); cfg_en in 1 channel run; cfg_ie in 1 interrupt enable.
REQ-005 irq_ack in 1 acknowledge of the currently presented interrupt.
REQ-006 tick out NCH one-cycle expiry pulse per channel; irq out 1 interrupt request; irq_ch out $clog2(NCH) serviced channel; irq_vec out VW jump vector.

Function
REQ-007 A shared 6-bit free-running prescaler counter SHALL increment every clk; strobe /1 every cycle, /4 when bits[1:0]==3, /16 when bits[3:0]==15, /64 when bits[5:0]==63.
REQ-008 cfg_we SHALL, at the edge, load the channel's count with cfg_period, store presc/periodic/en/ie, and clear that channel's pending bit.
REQ-009 On a selected strobe with en=1: count!=0 -> count-1; count==0 -> expiry.
REQ-010 Expiry SHALL register tick[ch]=1 for exactly one cycle, set pending[ch], reload cfg_period if periodic, else clear en (count stays 0).
REQ-011 Period P at /1 SHALL give first tick P+1 clocks after the write edge, then every P+1 clocks; P=0 periodic ticks every strobe.
REQ-012 Disabled channels SHALL hold count and never tick; pending bits SHALL be set regardless of ie.
REQ-013 irq SHALL be combinational OR of pending&ie; irq_ch SHALL be lowest index with pending&ie (0 if none); irq_vec SHALL be VEC_BASE + irq_ch*VEC_STRIDE, modulo 2^VW.
REQ-014 irq_ack with irq=1 SHALL clear pending[irq_ch] at the edge; irq_ack with irq=0 SHALL be ignored.
REQ-015 Same-cycle cfg_we and expiry on one channel: write wins, no tick, pending cleared.
REQ-016 Same-cycle ack and new expiry on the acked channel: set wins, pending stays 1.
REQ-017 Expiries on several channels in one cycle SHALL each set pending and tick independently.
REQ-018 cfg_ch >= NCH SHALL be ignored.

Reset
REQ-019 reset low SHALL immediately clear prescaler, all counts, configs, pending and tick; irq=0, irq_ch=0, irq_vec=VEC_BASE.
REQ-020 Release SHALL be synchronised to clk via 2-flop deassert synchroniser; first prescaler increment on the first edge after release.

Structure
REQ-021 Package timer_bank_pkg SHALL hold prescale-select encodings, the mode enum (ONESHOT, PERIODIC) and default VEC_BASE/VEC_STRIDE.
REQ-022 Per-channel count/config/expiry logic SHALL be sub-module timer_chan, generated NCH times; prescaler and priority encoder stay in timer_bank.

Verification
REQ-023 ch0 P=3 /1 periodic ie=1 -> tick[0] 4 clocks after write, then every 4; irq=1, irq_vec=0x384.
REQ-024 ch1 P=0 /4 one-shot -> single tick[1] at next bits[1:0]==3 strobe, en cleared, no further ticks over 64 clocks.
REQ-025 ch1, ch2 pending, ie=1 -> irq_ch=1, vec=0x388; ack -> irq_ch=2, vec=0x38C; ack -> irq=0.
REQ-026 ch3 ie=0 expires -> irq=0; ch2 expiry and ack of ch2 same cycle -> pending[2] stays 1.
REQ-027 cfg_we on ch0 in its expiry cycle -> no tick[0], count=new period, pending[0]=0.
REQ-028 reset low mid-count, off clock edge -> all outputs zero/VEC_BASE immediately; after release, ch0 idle until rewritten.
